// File: rtl/frame_writer_ctrl.sv
// Capture-side DDR write master: packs 64-bit pixel beats into fixed bursts and writes them
// into the frame slot chosen by the write pointer latched on the SOF beat.
module frame_writer_ctrl #(
  parameter int unsigned H_ACTIVE       = 1280,
  parameter int unsigned V_ACTIVE       = 720,
  parameter int unsigned BYTES_PER_PIX  = 4,
  parameter int unsigned BEAT_BYTES     = 8,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned LINE_STRIDE    = 8192,
  parameter logic [7:0]  FRAME_BASE_MSB = 8'h70
) (
  input  logic        cam_clk_i,
  input  logic        reset_i,
  input  logic [2:0]  wr_ptr_i,
  input  logic        sof_i,
  input  logic        data_valid_i,
  input  logic [63:0] data_i,
  output logic        data_ready_o,
  output logic        wr_req_o,
  output logic [31:0] wr_req_addr_o,
  output logic [7:0]  wr_req_len_o,
  input  logic        wr_req_ack_i,
  output logic [63:0] wr_data_o,
  output logic        wr_data_valid_o,
  output logic        wr_data_last_o,
  input  logic        wr_data_ready_i,
  output logic        frame_wr_done_o,
  output logic        frame_abort_o,
  output logic        frame_busy_o
);

  localparam int unsigned BurstBytes    = BURST_LEN * BEAT_BYTES;
  localparam int unsigned BurstsPerLine = (H_ACTIVE * BYTES_PER_PIX) / BurstBytes;
  localparam int unsigned BeatW         = $clog2(BURST_LEN);
  localparam int unsigned BurstW        = $clog2(BurstsPerLine + 1);
  localparam int unsigned LineW         = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {StIdle, StFill, StReq, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [LineW-1:0]    line_q, line_d;
  logic [2:0]          ptr_q, ptr_d;
  logic                abort_q, abort_d;
  logic [63:0]         burst_buf_q [BURST_LEN];
  logic                buf_we;
  logic [BeatW-1:0]    buf_waddr;
  logic                last_beat, last_burst_of_line, last_line;
  logic [31:0]         offset;

  assign last_beat          = (beat_q == BeatW'(BURST_LEN - 1));
  assign last_burst_of_line = (burst_q == BurstW'(BurstsPerLine - 1));
  assign last_line          = (line_q == LineW'(V_ACTIVE - 1));

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    burst_d      = burst_q;
    line_d       = line_q;
    ptr_d        = ptr_q;
    abort_d      = 1'b0;
    buf_we       = 1'b0;
    buf_waddr    = beat_q;
    data_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        data_ready_o = 1'b1;
        if (data_valid_i && sof_i) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          ptr_d     = wr_ptr_i;
          beat_d    = BeatW'(1);
          burst_d   = '0;
          line_d    = '0;
          state_d   = StFill;
        end
      end
      StFill: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          buf_we = 1'b1;
          if (sof_i) begin
            // Early SOF restarts the frame with this beat as beat 0.
            buf_waddr = '0;
            ptr_d     = wr_ptr_i;
            beat_d    = BeatW'(1);
            burst_d   = '0;
            line_d    = '0;
            abort_d   = 1'b1;
          end else if (last_beat) begin
            beat_d  = '0;
            state_d = StReq;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StReq: begin
        if (wr_req_ack_i) state_d = StDrain;
      end
      StDrain: begin
        if (wr_data_ready_i) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = StFill;
            if (last_burst_of_line) begin
              burst_d = '0;
              if (last_line) begin
                line_d  = '0;
                state_d = StDone;
              end else begin
                line_d = line_q + LineW'(1);
              end
            end else begin
              burst_d = burst_q + BurstW'(1);
            end
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cam_clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
      burst_q <= '0;
      line_q  <= '0;
      ptr_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      line_q  <= line_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;
    end
  end

  // Payload storage only; never observed outside StDrain, so no reset needed.
  always_ff @(posedge cam_clk_i) begin
    if (buf_we) burst_buf_q[buf_waddr] <= data_i;
  end

  assign offset = 32'(line_q) * LINE_STRIDE + 32'(burst_q) * BurstBytes;

  always_comb begin
    wr_req_o        = (state_q == StReq);
    wr_req_addr_o   = wr_req_o ? {FRAME_BASE_MSB[7:3], ptr_q, offset[23:0]} : '0;
    wr_req_len_o    = wr_req_o ? 8'(BURST_LEN - 1) : '0;
    wr_data_valid_o = (state_q == StDrain);
    wr_data_o       = wr_data_valid_o ? burst_buf_q[beat_q] : '0;
    wr_data_last_o  = wr_data_valid_o && last_beat;
    frame_wr_done_o = (state_q == StDone);
    frame_abort_o   = abort_q;
    frame_busy_o    = (state_q == StFill) || (state_q == StReq) || (state_q == StDrain);
  end

endmodule

// File: tb/tb_frame_writer_ctrl.sv
// Directed self-checking bench for frame_writer_ctrl on a small 64x2 frame (2 bursts per line).
module tb_frame_writer_ctrl;

  logic        cam_clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [2:0]  wr_ptr_i = '0;
  logic        sof_i = 1'b0;
  logic        data_valid_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        data_ready_o;
  logic        wr_req_o;
  logic [31:0] wr_req_addr_o;
  logic [7:0]  wr_req_len_o;
  logic        wr_req_ack_i = 1'b0;
  logic [63:0] wr_data_o;
  logic        wr_data_valid_o;
  logic        wr_data_last_o;
  logic        wr_data_ready_i = 1'b1;
  logic        frame_wr_done_o;
  logic        frame_abort_o;
  logic        frame_busy_o;

  int vectors = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  frame_writer_ctrl #(
    .H_ACTIVE(64),
    .V_ACTIVE(2),
    .LINE_STRIDE(512)
  ) dut (
    .cam_clk_i(cam_clk_i),
    .reset_i(reset_i),
    .wr_ptr_i(wr_ptr_i),
    .sof_i(sof_i),
    .data_valid_i(data_valid_i),
    .data_i(data_i),
    .data_ready_o(data_ready_o),
    .wr_req_o(wr_req_o),
    .wr_req_addr_o(wr_req_addr_o),
    .wr_req_len_o(wr_req_len_o),
    .wr_req_ack_i(wr_req_ack_i),
    .wr_data_o(wr_data_o),
    .wr_data_valid_o(wr_data_valid_o),
    .wr_data_last_o(wr_data_last_o),
    .wr_data_ready_i(wr_data_ready_i),
    .frame_wr_done_o(frame_wr_done_o),
    .frame_abort_o(frame_abort_o),
    .frame_busy_o(frame_busy_o)
  );

  always #5 cam_clk_i = ~cam_clk_i;

  always @(posedge cam_clk_i) begin
    if (!reset_i) begin
      if (frame_wr_done_o) done_cnt++;
      if (frame_abort_o) abort_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [2:0] slot, input int b);
    return {5'b01110, slot, 24'((b / 2) * 512 + (b % 2) * 128)};
  endfunction

  // Entered and left on a falling edge.
  task automatic push(input logic [63:0] d, input logic s);
    int n = 0;
    data_valid_i = 1'b1;
    data_i = d;
    sof_i = s;
    while (!data_ready_o && n < 100) begin
      @(negedge cam_clk_i);
      n++;
    end
    check("push_ready", 64'(data_ready_o), 64'd1);
    @(negedge cam_clk_i);
    data_valid_i = 1'b0;
    sof_i = 1'b0;
  endtask

  task automatic drain_burst(input logic [31:0] addr, input logic [63:0] first,
                             input int ack_delay, input bit toggle);
    int n = 0;
    int i = 0;
    while (!wr_req_o && n < 50) begin
      @(negedge cam_clk_i);
      n++;
    end
    check("req_seen", 64'(wr_req_o), 64'd1);
    check("req_addr", 64'(wr_req_addr_o), 64'(addr));
    check("req_len", 64'(wr_req_len_o), 64'd15);
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge cam_clk_i);
      check("req_hold", 64'(wr_req_o), 64'd1);
      check("addr_hold", 64'(wr_req_addr_o), 64'(addr));
      check("stall_ready", 64'(data_ready_o), 64'd0);
    end
    wr_req_ack_i = 1'b1;
    @(negedge cam_clk_i);
    wr_req_ack_i = 1'b0;
    check("req_drop", 64'(wr_req_o), 64'd0);
    n = 0;
    while (i < 16 && n < 200) begin
      wr_data_ready_i = toggle ? n[0] : 1'b1;
      if (wr_data_ready_i && wr_data_valid_o) begin
        check("beat_data", wr_data_o, first + 64'(i));
        check("beat_last", 64'(wr_data_last_o), 64'(i == 15));
        i++;
      end
      @(negedge cam_clk_i);
      n++;
    end
    wr_data_ready_i = 1'b1;
    check("beat_count", 64'(i), 64'd16);
  endtask

  // Four bursts; first beat uses ptr0, the rest drive ptr1 (which must be ignored).
  task automatic send_frame(input logic [2:0] ptr0, input logic [2:0] ptr1,
                            input logic [63:0] base, input int ack_delay, input bit toggle);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) begin
        wr_ptr_i = (b == 0 && i == 0) ? ptr0 : ptr1;
        push(base + 64'(b * 16 + i), (b == 0 && i == 0));
        if (b == 0 && i == 0) check("busy_after_sof", 64'(frame_busy_o), 64'd1);
      end
      drain_burst(exp_addr(ptr0, b), base + 64'(b * 16), ack_delay, toggle);
      check("done_pulse", 64'(frame_wr_done_o), 64'(b == 3));
    end
    check("busy_at_done", 64'(frame_busy_o), 64'd0);
    @(negedge cam_clk_i);
    check("done_single", 64'(frame_wr_done_o), 64'd0);
    check("idle_ready", 64'(data_ready_o), 64'd1);
  endtask

  initial begin
    // 1: reset
    reset_i = 1'b1;
    repeat (2) @(posedge cam_clk_i);
    @(negedge cam_clk_i);
    reset_i = 1'b0;
    check("rst_ready", 64'(data_ready_o), 64'd1);
    check("rst_req", 64'(wr_req_o), 64'd0);
    check("rst_addr", 64'(wr_req_addr_o), 64'd0);
    check("rst_len", 64'(wr_req_len_o), 64'd0);
    check("rst_data", wr_data_o, 64'd0);
    check("rst_valid", 64'(wr_data_valid_o), 64'd0);
    check("rst_last", 64'(wr_data_last_o), 64'd0);
    check("rst_done", 64'(frame_wr_done_o), 64'd0);
    check("rst_abort", 64'(frame_abort_o), 64'd0);
    check("rst_busy", 64'(frame_busy_o), 64'd0);

    // 2: full frame to slot 3, no backpressure
    send_frame(3'd3, 3'd3, 64'hA000_0000_0000_0000, 0, 1'b0);
    check("done_cnt_2", 64'(done_cnt), 64'd1);

    // 3: same frame, delayed ack and toggling write-ready
    send_frame(3'd3, 3'd3, 64'hA000_0000_0000_0000, 5, 1'b1);
    check("done_cnt_3", 64'(done_cnt), 64'd2);

    // 4: SOF after 7 beats aborts; restarted frame goes to slot 5
    for (int i = 0; i < 7; i++) begin
      wr_ptr_i = 3'd1;
      push(64'hB000_0000_0000_0000 + 64'(i), (i == 0));
    end
    check("abort_busy", 64'(frame_busy_o), 64'd1);
    check("abort_none_yet", 64'(abort_cnt), 64'd0);
    send_frame(3'd5, 3'd5, 64'hC000_0000_0000_0000, 1, 1'b0);
    check("abort_cnt_4", 64'(abort_cnt), 64'd1);
    check("done_cnt_4", 64'(done_cnt), 64'd3);

    // 5: pointer change mid-frame is ignored
    send_frame(3'd2, 3'd4, 64'hD000_0000_0000_0000, 0, 1'b0);
    check("done_cnt_5", 64'(done_cnt), 64'd4);

    // 6: beats without SOF in idle are dropped
    for (int i = 0; i < 10; i++) begin
      check("idle_drop_ready", 64'(data_ready_o), 64'd1);
      push(64'hE000_0000_0000_0000 + 64'(i), 1'b0);
      check("idle_drop_req", 64'(wr_req_o), 64'd0);
      check("idle_drop_busy", 64'(frame_busy_o), 64'd0);
    end

    // Reset while a request is pending
    for (int i = 0; i < 16; i++) push(64'hF000_0000_0000_0000 + 64'(i), (i == 0));
    check("pre_rst_req", 64'(wr_req_o), 64'd1);
    reset_i = 1'b1;
    @(negedge cam_clk_i);
    check("mid_rst_req", 64'(wr_req_o), 64'd0);
    check("mid_rst_ready", 64'(data_ready_o), 64'd1);
    reset_i = 1'b0;
    wr_req_ack_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge cam_clk_i);
      check("post_rst_req", 64'(wr_req_o), 64'd0);
      check("post_rst_valid", 64'(wr_data_valid_o), 64'd0);
    end
    wr_req_ack_i = 1'b0;
    check("abort_cnt_end", 64'(abort_cnt), 64'd1);
    check("done_cnt_end", 64'(done_cnt), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
